// File: rtl/seq_div_pkg.sv
// Shared types for the sequential divider: FSM state encoding.
package seq_div_pkg;

  localparam logic [1:0] StIdleEnc = 2'b00;
  localparam logic [1:0] StCalcEnc = 2'b01;
  localparam logic [1:0] StDoneEnc = 2'b10;

  typedef enum logic [1:0] {
    StIdle = StIdleEnc,
    StCalc = StCalcEnc,
    StDone = StDoneEnc
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference if it did not go negative.
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,  // partial remainder, always < dvs_i
  input  logic [WIDTH-1:0] dvd_i,  // dividend bits not yet consumed, quotient bits in the low end
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  // Shift, trial subtract, select.
  always_comb begin
    rem_sh = {rem_i, dvd_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_i};
    ge     = (rem_sh >= {1'b0, dvs_i});
    rem_o  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_o  = {dvd_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/seq_div_mod.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle, optional signed mode.
// Signs are stripped on operand capture and reapplied on entry to DONE.
module seq_div_mod #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  import seq_div_pkg::*;

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_dvd;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_i(rem_q),
    .dvd_i(dvd_q),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .dvd_o(step_dvd)
  );

  // Operand magnitudes; the most-negative value maps onto its unsigned magnitude.
  always_comb begin
    sgn   = SIGNED_EN && signed_mode;
    a_neg = sgn && dividend[WIDTH-1];
    b_neg = sgn && divisor[WIDTH-1];
    a_mag = a_neg ? (~dividend + One) : dividend;
    b_mag = b_neg ? (~divisor + One) : divisor;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (divisor == '0) begin
            // No iterations needed; results are defined directly.
            state_d     = StDone;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = StCalc;
            busy_d  = 1'b1;
            cnt_d   = '0;
            rem_d   = '0;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dbz_d   = 1'b0;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StCalc: begin
        busy_d = 1'b1;
        rem_d  = step_rem;
        dvd_d  = step_dvd;
        cnt_d  = cnt_q + CntOne;
        if (cnt_q == CntLast) begin
          state_d     = StDone;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          quotient_d  = qneg_q ? (~step_dvd + One) : step_dvd;
          remainder_d = rneg_q ? (~step_rem + One) : step_rem;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_mod.sv
// Self-checking bench for seq_div_mod (WIDTH=8): vector table, corner sequences, random ops.
module tb_seq_div_mod;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  seq_div_mod #(
    .WIDTH(W),
    .SIGNED_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .signed_mode(signed_mode),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         s;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Division rules stated as plain integer arithmetic.
  function automatic void model(input bit s, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r, output logic dbz);
    int sa, sb;
    dbz = 1'b0;
    if (b == 8'd0) begin
      q   = 8'hFF;
      r   = a;
      dbz = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -128 && sb == -1) begin
        q = 8'h80;
        r = 8'h00;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
    end else begin
      q = 8'(int'(a) / int'(b));
      r = 8'(int'(a) % int'(b));
    end
  endfunction

  // Issue one operation and wait (bounded) for done; lat counts cycles after the accepting edge.
  task automatic do_op(input bit s, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic dbz,
                       output int lat, output int bcnt);
    @(negedge clk);
    start       = 1'b1;
    signed_mode = s;
    dividend    = a;
    divisor     = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
    lat  = 1;
    bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
    q   = quotient;
    r   = remainder;
    dbz = div_by_zero;
  endtask

  vec_t       vecs[$];
  logic [7:0] q, r, eq, er;
  logic       dbz, edbz;
  int         lat, bcnt;
  bit         any_done;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_q", 32'(quotient), 0);
    chk("rst_r", 32'(remainder), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    chk("rst_prio_busy", 32'(busy), 0);
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_prio_idle", 32'(busy), 0);

    vecs.push_back('{0, 8'd100, 8'd7,  8'd14,  8'd2,   0, 9});
    vecs.push_back('{1, 8'hF9,  8'h02, 8'hFD,  8'hFF,  0, 9});
    vecs.push_back('{1, 8'h07,  8'hFE, 8'hFD,  8'h01,  0, 9});
    vecs.push_back('{0, 8'd55,  8'd0,  8'hFF,  8'd55,  1, 1});
    vecs.push_back('{0, 8'd9,   8'd3,  8'd3,   8'd0,   0, 9});
    vecs.push_back('{1, 8'h80,  8'hFF, 8'h80,  8'h00,  0, 9});
    vecs.push_back('{0, 8'd255, 8'd16, 8'd15,  8'd15,  0, 9});
    vecs.push_back('{0, 8'h80,  8'hFF, 8'h00,  8'h80,  0, 9});
    vecs.push_back('{1, 8'h05,  8'hF9, 8'h00,  8'h05,  0, 9});
    vecs.push_back('{0, 8'd200, 8'd1,  8'd200, 8'd0,   0, 9});
    vecs.push_back('{1, 8'h80,  8'h00, 8'hFF,  8'h80,  1, 1});
    vecs.push_back('{1, 8'h81,  8'h7F, 8'hFF,  8'h00,  0, 9});

    foreach (vecs[i]) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, q, r, dbz, lat, bcnt);
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d_r", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("vec%0d_dbz", i), 32'(dbz), 32'(vecs[i].dbz));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'(vecs[i].lat - 1));
    end

    // done is a single-cycle pulse followed by idle.
    @(posedge clk);
    #1;
    chk("done_pulse", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);

    // A start in CALC cycle 3 is ignored; results stay frozen until DONE.
    do_op(0, 8'd9, 8'd3, q, r, dbz, lat, bcnt);
    chk("pre_ign_q", 32'(q), 3);
    @(negedge clk);
    start       = 1'b1;
    signed_mode = 1'b0;
    dividend    = 8'd100;
    divisor     = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    start       = 1'b1;
    signed_mode = 1'b1;
    dividend    = 8'd50;
    divisor     = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 4;
    chk("ign_busy", 32'(busy), 1);
    chk("ign_hold_q", 32'(quotient), 3);
    chk("ign_hold_r", 32'(remainder), 0);
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done) lat = -1;
    chk("ign_lat", 32'(lat), 9);
    chk("ign_q", 32'(quotient), 14);
    chk("ign_r", 32'(remainder), 2);

    // Reset in CALC cycle 4 aborts with no done, then a fresh op works.
    @(negedge clk);
    start       = 1'b1;
    signed_mode = 1'b0;
    dividend    = 8'd200;
    divisor     = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_pre_busy", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_q", 32'(quotient), 0);
    chk("abort_r", 32'(remainder), 0);
    chk("abort_dbz", 32'(div_by_zero), 0);
    @(negedge clk);
    rst      = 1'b0;
    any_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done || busy) any_done = 1'b1;
    end
    chk("abort_quiet", 32'(any_done), 0);
    do_op(0, 8'd77, 8'd5, q, r, dbz, lat, bcnt);
    chk("post_abort_q", 32'(q), 15);
    chk("post_abort_r", 32'(r), 2);
    chk("post_abort_lat", 32'(lat), 9);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 150; i++) begin
      bit         s;
      logic [7:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        a = 8'h80;
        b = 8'hFF;
      end
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      do_op(s, a, b, q, r, dbz, lat, bcnt);
      model(s, a, b, eq, er, edbz);
      chk($sformatf("rnd%0d_q s=%0d a=%0h b=%0h", i, s, a, b), 32'(q), 32'(eq));
      chk($sformatf("rnd%0d_r s=%0d a=%0h b=%0h", i, s, a, b), 32'(r), 32'(er));
      chk($sformatf("rnd%0d_dbz", i), 32'(dbz), 32'(edbz));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), (b == 8'd0) ? 32'd1 : 32'd9);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
